// File: rtl/adc_sample_feeder.sv
// Purpose: decimating ADC front end. Averages 2^DECIM_LOG2 offset-binary samples into one signed, scaled, saturated output sample.
// Latency: en_out/x_out update on the cycle after the last sample of a group is accepted.
// Backpressure: adc_ready drops for one EMIT cycle after each group. FEEDER_ROUND_EN selects round-half-up; when undefined, the result is truncated.
module adc_sample_feeder #(
    parameter int ADC_W      = 12,
    parameter int Width      = 10,
    parameter int DECIM_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic             adc_ready,
    output logic             en_out,
    output logic [Width-1:0] x_out
);

    localparam int AW   = ADC_W + DECIM_LOG2;          // accumulator width, cannot overflow
    localparam int AW1  = AW + 1;                      // headroom for the rounding add
    localparam int CW   = DECIM_LOG2 + 1;              // sample counter width
    localparam int S    = DECIM_LOG2 + ADC_W - Width;  // output scaling shift
    localparam int LAST = (1 << DECIM_LOG2) - 1;       // counter value of the final sample in a group

    localparam logic signed [AW1-1:0] MAXV = AW1'((1 << (Width-1)) - 1);
    localparam logic signed [AW1-1:0] MINV = ~MAXV;

    typedef enum logic {ACCUM, EMIT} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic signed [AW-1:0]    r_acc;
    logic        [CW-1:0]    r_cnt;
    logic                    r_en;
    logic        [Width-1:0] r_x;

    logic                    w_accept;
    logic                    w_last;
    logic signed [ADC_W-1:0] w_samp;
    logic signed [AW-1:0]    w_sum;
    logic signed [AW1-1:0]   w_pre;
    logic signed [AW1-1:0]   w_shf;
    logic        [Width-1:0] w_res;

    // Offset binary to two's complement: flip the MSB.
    assign w_samp = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};
    assign w_sum  = r_acc + AW'(w_samp);
    assign w_last = (r_cnt == CW'(LAST));

`ifdef FEEDER_ROUND_EN
    localparam int RND = (S > 0) ? (1 << ((S > 0) ? (S - 1) : 0)) : 0;
    assign w_pre = AW1'(w_sum) + AW1'(RND);
`else
    assign w_pre = AW1'(w_sum);
`endif

    assign w_shf = w_pre >>> S;

    // Clamp the scaled group sum into the signed output range.
    always_comb begin
        w_res = Width'(w_shf);
        if (w_shf > MAXV) begin
            w_res = Width'(MAXV);
        end else if (w_shf < MINV) begin
            w_res = Width'(MINV);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, handshake and acceptance qualification. clr beats a same-cycle sample.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        adc_ready = 1'b0;
        case (r_state)
            ACCUM: begin
                adc_ready = 1'b1;
                w_accept  = adc_valid && !clr;
                if (w_accept && w_last) begin
                    w_next = EMIT;
                end
            end
            EMIT: begin
                w_next = ACCUM;
            end
            default: begin
                w_next = ACCUM;
            end
        endcase
    end

    // Accumulator, counter and output registers. en_out is a single-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_en  <= 1'b0;
            r_x   <= '0;
        end else begin
            r_en <= 1'b0;
            if (r_state == EMIT || clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_x   <= w_res;
                    r_en  <= 1'b1;
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign en_out = r_en;
    assign x_out  = r_x;

endmodule

// File: tb/tb_adc_sample_feeder.sv
// Purpose: directed self-checking bench for adc_sample_feeder at default parameters.
// Latency: expects en_out/x_out one cycle after the fourth accepted sample.
// Backpressure: checks the one-cycle adc_ready drop after every group.
module tb_adc_sample_feeder;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic        adc_ready;
    logic        en_out;
    logic [9:0]  x_out;

    int n_chk;
    int n_pass;
    int en_cnt;

    adc_sample_feeder #(.ADC_W(12), .Width(10), .DECIM_LOG2(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .adc_ready (adc_ready),
        .en_out    (en_out),
        .x_out     (x_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count strobes on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (en_out === 1'b1) en_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and hold it until accepted (bounded wait).
    task automatic push(input logic [11:0] d);
        int t;
        adc_data  = d;
        adc_valid = 1'b1;
        t = 0;
        while (adc_ready !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        check("push_ready", {31'd0, adc_ready}, 32'd1);
        step();
        adc_valid = 1'b0;
    endtask

    task automatic group(input logic [11:0] d0, input logic [11:0] d1,
                         input logic [11:0] d2, input logic [11:0] d3,
                         input logic [9:0] exp_x, input string tag);
        int e0;
        e0 = en_cnt;
        push(d0);
        push(d1);
        push(d2);
        check({tag, "_no_early_en"}, {31'd0, en_out}, 32'd0);
        push(d3);
        check({tag, "_en"}, {31'd0, en_out}, 32'd1);
        check({tag, "_x"}, {22'd0, x_out}, {22'd0, exp_x});
        check({tag, "_ready_low"}, {31'd0, adc_ready}, 32'd0);
        step();
        check({tag, "_en_one_cycle"}, {31'd0, en_out}, 32'd0);
        check({tag, "_x_hold"}, {22'd0, x_out}, {22'd0, exp_x});
        check({tag, "_ready_back"}, {31'd0, adc_ready}, 32'd1);
        check({tag, "_en_count"}, en_cnt - e0, 32'd1);
    endtask

    initial begin
        int e0;
        int rdy_low;
        int pulses;
        int last_i;
        n_chk = 0;
        n_pass = 0;
        en_cnt = 0;
        rst_n = 1'b1;
        clr = 1'b0;
        adc_valid = 1'b0;
        adc_data = 12'd0;

        // Reset values.
        #3 rst_n = 1'b0;
        #1;
        check("rst_x", {22'd0, x_out}, 32'd0);
        check("rst_en", {31'd0, en_out}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("ready_after_rst", {31'd0, adc_ready}, 32'd1);

        // Mid-scale, full-scale, zero-scale groups.
        group(12'd2048, 12'd2048, 12'd2048, 12'd2048, 10'd0, "mid");
        group(12'd4095, 12'd4095, 12'd4095, 12'd4095, 10'd511, "max");
        group(12'd0, 12'd0, 12'd0, 12'd0, 10'h200, "min");
`ifdef FEEDER_ROUND_EN
        group(12'd2047, 12'd2047, 12'd2047, 12'd2046, 10'd0, "small_neg");
`else
        group(12'd2047, 12'd2047, 12'd2047, 12'd2046, 10'h3FF, "small_neg");
`endif

        // Partial group discarded by clr; the sample offered with clr is dropped too.
        e0 = en_cnt;
        push(12'd4095);
        push(12'd4095);
        clr = 1'b1;
        adc_valid = 1'b1;
        adc_data = 12'd4095;
        step();
        clr = 1'b0;
        adc_valid = 1'b0;
        step();
        check("clr_no_en", en_cnt - e0, 32'd0);
        group(12'd2208, 12'd2208, 12'd2208, 12'd2208, 10'd40, "after_clr");

        // Streaming: valid held 20 cycles.
        rdy_low = 0;
        pulses = 0;
        last_i = -1;
        adc_valid = 1'b1;
        adc_data = 12'd4095;
        for (int i = 0; i < 20; i++) begin
            if (adc_ready === 1'b0) rdy_low++;
            if (en_out === 1'b1) begin
                pulses++;
                if (last_i < 0) check("stream_first_en", i, 32'd4);
                else check("stream_spacing", i - last_i, 32'd5);
                last_i = i;
            end
            step();
        end
        adc_valid = 1'b0;
        check("stream_ready_low", rdy_low, 32'd4);
        check("stream_pulses", pulses, 32'd4);
        check("stream_x", {22'd0, x_out}, 32'd511);

        // Reset mid-accumulation discards the partial sum.
        push(12'd4095);
        push(12'd4095);
        push(12'd4095);
        rst_n = 1'b0;
        #1;
        check("midrst_x", {22'd0, x_out}, 32'd0);
        check("midrst_en", {31'd0, en_out}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        e0 = en_cnt;
        push(12'd2048);
        push(12'd2048);
        push(12'd2048);
        check("midrst_no_early", en_cnt - e0, 32'd0);
        push(12'd2048);
        check("midrst_en_final", {31'd0, en_out}, 32'd1);
        check("midrst_x_final", {22'd0, x_out}, 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
